// File: rtl/bnn_sample_driver.sv
// Host-side initiator for the BNN classifier: collects a two-byte sample,
// gates classifier enable, discards stale DONEs and returns one result byte.
module bnn_sample_driver #(
   parameter int DISCARD_DONES  = 1,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic [7:0] feat_a,
   output logic [7:0] feat_b,
   output logic       clf_ena,
   input  logic [7:0] clf_result,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       busy
);

   localparam int DW = (DISCARD_DONES > 0) ? $clog2(DISCARD_DONES + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DISC  = DW'(DISCARD_DONES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GET_B,
      S_WAIT,
      S_EMIT
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    feat_a_q, feat_a_d;
   logic [7:0]    feat_b_q, feat_b_d;
   logic [7:0]    m_data_q, m_data_d;
   logic [DW-1:0] done_cnt_q, done_cnt_d;
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic          done;

   assign done = clf_result[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         feat_a_q   <= '0;
         feat_b_q   <= '0;
         m_data_q   <= '0;
         done_cnt_q <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         feat_a_q   <= feat_a_d;
         feat_b_q   <= feat_b_d;
         m_data_q   <= m_data_d;
         done_cnt_q <= done_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      feat_a_d   = feat_a_q;
      feat_b_d   = feat_b_q;
      m_data_d   = m_data_q;
      done_cnt_d = done_cnt_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               feat_a_d = s_data;
               state_d  = S_GET_B;
            end
         end
         S_GET_B: begin
            if (s_valid) begin
               feat_b_d   = s_data;
               done_cnt_d = '0;
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // a discarded DONE does not advance the timeout counter
            if (done && (done_cnt_q < DISC)) begin
               done_cnt_d = done_cnt_q + 1'b1;
            end else if (done) begin
               m_data_d = {clf_result[7:4], 1'b0, clf_result[2:0]};
               state_d  = S_EMIT;
            end else if (wait_cnt_q == TLAST) begin
               m_data_d = 8'b0000_1_000;
               state_d  = S_EMIT;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_EMIT: begin
            if (m_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   assign s_ready = (state_q == S_IDLE) || (state_q == S_GET_B);
   assign clf_ena = (state_q == S_WAIT);
   assign m_valid = (state_q == S_EMIT);
   assign busy    = (state_q != S_IDLE);
   assign feat_a  = feat_a_q;
   assign feat_b  = feat_b_q;
   assign m_data  = m_data_q;

endmodule
